// File: rtl/access_session_if.sv
// access_session_if: switch/button inputs, checker link and session status outputs.
interface access_session_if;
  logic [2:0] sw;
  logic       confirm_btn;
  logic       logout;
  logic [2:0] user_q;
  logic [2:0] func_q;
  logic [2:0] perm_s;
  logic [2:0] grant_func;
  logic       grant_valid;
  logic       deny;
  logic       locked;
  logic       session_active;
  modport master (
    output sw, confirm_btn, logout, perm_s,
    input  user_q, func_q, grant_func, grant_valid, deny, locked, session_active
  );
  modport slave (
    input  sw, confirm_btn, logout, perm_s,
    output user_q, func_q, grant_func, grant_valid, deny, locked, session_active
  );
endinterface

// File: rtl/access_session_ctrl.sv
// access_session_ctrl: user/function capture, timed grant or deny, fail lockout and idle expiry.
module access_session_ctrl #(
  parameter int MAX_FAILS      = 3,
  parameter int LOCK_CYCLES    = 16,
  parameter int GRANT_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 32
) (
  input logic clk,
  input logic rst_n,
  access_session_if.slave bus
);
  localparam int FW   = $clog2(MAX_FAILS + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HMAX = (LOCK_CYCLES > GRANT_CYCLES) ? LOCK_CYCLES : GRANT_CYCLES;
  localparam int HW   = $clog2(HMAX + 1);
  typedef enum logic [2:0] {IDLE, SELECT, CHECK, GRANT, LOCKED} state_t;
  state_t        state_q;
  logic [2:0]    sync_q;
  logic [2:0]    user_q, func_q, grant_func_q;
  logic          grant_valid_q, deny_q, locked_q, active_q;
  logic [FW-1:0] fail_q;
  logic [TW-1:0] tmo_q;
  logic [HW-1:0] hold_q;
  logic          cfm;
  // two synchronizer flops followed by the edge-detect flop
  assign cfm = sync_q[1] & ~sync_q[2];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q        <= '0;
      state_q       <= IDLE;
      user_q        <= '0;
      func_q        <= '0;
      grant_func_q  <= '0;
      grant_valid_q <= 1'b0;
      deny_q        <= 1'b0;
      locked_q      <= 1'b0;
      active_q      <= 1'b0;
      fail_q        <= '0;
      tmo_q         <= '0;
      hold_q        <= '0;
    end else begin
      sync_q <= {sync_q[1:0], bus.confirm_btn};
      deny_q <= 1'b0;
      case (state_q)
        IDLE:
          if (cfm && bus.sw != 3'b000) begin
            user_q   <= bus.sw;
            func_q   <= '0;
            fail_q   <= '0;
            tmo_q    <= '0;
            active_q <= 1'b1;
            state_q  <= SELECT;
          end
        SELECT:
          if (bus.logout || (cfm && bus.sw == 3'b000) || (!cfm && tmo_q == TW'(TIMEOUT_CYCLES - 1))) begin
            user_q   <= '0;
            func_q   <= '0;
            fail_q   <= '0;
            active_q <= 1'b0;
            state_q  <= IDLE;
          end else if (cfm) begin
            func_q  <= bus.sw;
            state_q <= CHECK;
          end else tmo_q <= tmo_q + 1'b1;
        CHECK: begin
          hold_q <= '0;
          if (bus.perm_s != 3'b000) begin
            grant_func_q  <= bus.perm_s;
            grant_valid_q <= 1'b1;
            fail_q        <= '0;
            state_q       <= GRANT;
          end else begin
            deny_q <= 1'b1;
            fail_q <= fail_q + 1'b1;
            if (fail_q + 1'b1 == FW'(MAX_FAILS)) begin
              locked_q <= 1'b1;
              active_q <= 1'b0;
              user_q   <= '0;
              func_q   <= '0;
              state_q  <= LOCKED;
            end else begin
              tmo_q   <= '0;
              state_q <= SELECT;
            end
          end
        end
        GRANT:
          if (hold_q == HW'(GRANT_CYCLES - 1)) begin
            grant_valid_q <= 1'b0;
            grant_func_q  <= '0;
            tmo_q         <= '0;
            state_q       <= SELECT;
          end else hold_q <= hold_q + 1'b1;
        LOCKED:
          if (hold_q == HW'(LOCK_CYCLES - 1)) begin
            locked_q <= 1'b0;
            fail_q   <= '0;
            state_q  <= IDLE;
          end else hold_q <= hold_q + 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  assign bus.user_q         = user_q;
  assign bus.func_q         = func_q;
  assign bus.grant_func     = grant_func_q;
  assign bus.grant_valid    = grant_valid_q;
  assign bus.deny           = deny_q;
  assign bus.locked         = locked_q;
  assign bus.session_active = active_q;
endmodule
